hci_copy_sink_lockstep: RTL and testbench
=========================================

Name: hci_copy_sink_lockstep

Overview:
Receiving end of the HCI duplicated-stream fault-detection chain.
- Accepts the main request stream on `tcdm_main` and forwards it unchanged to `tcdm_out`.
- Returns the responses from `tcdm_out` to `tcdm_main`.
- Accepts the redundant request stream on `tcdm_copy`. This stream may lag main by a fixed DELAY cycles (temporal lockstep).
- Compares the delayed main request bundle against the copy request bundle.
- Replays the delayed response bundle onto `tcdm_copy`, so the redundant upstream chain observes identical responses.

Parameters:
- DELAY, 0, cycles by which `tcdm_copy` lags `tcdm_main`; legal range 0..15.
- CNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- tcdm_main  hci_core_intf.target  -  main request stream from the upstream chain.
- tcdm_copy  hci_core_intf.target  -  redundant request stream, DELAY cycles behind main.
- tcdm_out  hci_core_intf.initiator  -  forwarded main stream to memory/interconnect.
- clear_i  input  1  synchronous clear of the sticky flag and the counter.
- fault_detected_o  output  1  registered per-cycle mismatch pulse.
- fault_sticky_o  output  1  set on any fault; held until clear_i.
- fault_count_o  output  CNT_WIDTH  saturating count of fault cycles.

Behaviour:
- Bundle definitions:
  - REQ bundle = {req, ereq, r_eready, ecc, add, wen, data, be, r_ready, user, id}.
  - RSP bundle = {gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc}.
  - All widths come from the interface parameters; `tcdm_copy` uses the same parameters as `tcdm_main`.
- Forward path is combinational with zero latency:
  - `tcdm_out` REQ = `tcdm_main` REQ.
  - `tcdm_main` RSP = `tcdm_out` RSP.
- Delay lines: a DELAY-stage shift register for REQ (from `tcdm_main`) and one for RSP (from `tcdm_out`).
  - Both shift every cycle, with no enable.
  - All stages reset to all-zero.
  - DELAY=0: no registers; the delayed value equals the current value, combinationally.
- Copy response: `tcdm_copy` RSP = delayed RSP (stage DELAY output).
- Compare: mismatch = (delayed REQ != `tcdm_copy` REQ), evaluated bitwise over the full bundle, X-free.
- Warm-up FSM with states WARMUP and ACTIVE; the counter is internal, $clog2(DELAY+1) bits.
  - Reset enters WARMUP with the counter = 0.
  - In WARMUP the counter increments each cycle; when it reaches DELAY the FSM moves to ACTIVE.
  - DELAY=0: reset enters ACTIVE directly.
  - Compare is masked in WARMUP, because the delay lines still hold reset zeros.
  - ACTIVE is held until reset.
- fault_detected_o: registered, value = mismatch & ACTIVE. A mismatch at cycle t gives fault_detected_o=1 at t+1. Reset value 0.
- fault_sticky_o:
  - Next value = fault_next | (fault_sticky_o & ~clear_i), where fault_next = mismatch & ACTIVE.
  - Reset value 0.
  - Set wins over a simultaneous clear_i.
- fault_count_o:
  - Reset value 0.
  - clear_i alone: next value = 0.
  - clear_i with fault_next in the same cycle: next value = 1.
  - Otherwise, on fault_next: increment, saturating at 2^CNT_WIDTH-1 (no wrap).
- Reset mid-operation:
  - All delay stages, the FSM, and all fault outputs return to reset values asynchronously.
  - The FSM re-enters WARMUP, so no spurious fault is raised while the lines refill.
- No backpressure is inserted. `tcdm_main` handshake timing is identical to `tcdm_out`.

Test Plan:
- DELAY=0, identical main/copy streams: write add=0x100 data=0xDEADBEEF, then read.
  - Required: `tcdm_copy`.r_data equals `tcdm_main`.r_data in the same cycle.
  - Required: fault_detected_o=0 throughout; fault_count_o=0.
- DELAY=3, copy driven 3 cycles behind main, 20 mixed transactions.
  - Required: zero faults.
  - Required: `tcdm_copy`.gnt/r_valid equal `tcdm_out` values from 3 cycles earlier.
- DELAY=3, flip copy data bit 5 on one request at cycle 10.
  - Required: fault_detected_o=1 at cycle 11 only.
  - Required: sticky=1 from cycle 11; count=1.
- DELAY=2, mismatching copy during the first 2 cycles after reset release.
  - Required: no fault (WARMUP masking).
  - Required: a mismatch at cycle 5 then flags at cycle 6.
- CNT_WIDTH=2, persistent mismatch for 6 cycles.
  - Required: count saturates at 3.
  - Required: clear_i together with a fault gives count=1, sticky=1.
  - Required: clear_i without a fault gives count=0, sticky=0.
- Assert rst_ni mid-stream with DELAY=4.
  - Required: all outputs 0 immediately.
  - Required: after release, 4 warm-up cycles with no fault, then normal compare.

Source files
------------

// File: rtl/hci_copy_sink_lockstep_if.sv
// HCI core request/response bundle between an initiator and a target.
// Width parameters must match the lockstep sink's width parameters.
interface hci_core_intf #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int BW  = DW / 8,
   parameter int UW  = 1,
   parameter int IW  = 1,
   parameter int EW  = 1,
   parameter int EHW = 1
) ();

   logic           req;
   logic           gnt;
   logic [AW-1:0]  add;
   logic           wen;
   logic [DW-1:0]  data;
   logic [BW-1:0]  be;
   logic           r_ready;
   logic [UW-1:0]  user;
   logic [IW-1:0]  id;
   logic [DW-1:0]  r_data;
   logic           r_valid;
   logic [UW-1:0]  r_user;
   logic [IW-1:0]  r_id;
   logic           r_opc;
   logic [EHW-1:0] ereq;
   logic [EHW-1:0] egnt;
   logic [EHW-1:0] r_evalid;
   logic [EHW-1:0] r_eready;
   logic [EW-1:0]  ecc;
   logic [EW-1:0]  r_ecc;

   modport initiator (
      output req, add, wen, data, be, r_ready, user, id, ereq, r_eready, ecc,
      input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
   );

   modport target (
      input  req, add, wen, data, be, r_ready, user, id, ereq, r_eready, ecc,
      output gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
   );

   modport master (
      output req, add, wen, data, be, r_ready, user, id, ereq, r_eready, ecc,
      input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
   );

   modport slave (
      input  req, add, wen, data, be, r_ready, user, id, ereq, r_eready, ecc,
      output gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
   );

endinterface

// File: rtl/hci_copy_sink_lockstep.sv
// Lockstep sink: forwards the main stream, delays main REQ/RSP by DELAY cycles,
// compares against the redundant copy stream and replays delayed responses to it.
module hci_copy_sink_lockstep #(
   parameter int DELAY     = 0,
   parameter int CNT_WIDTH = 8,
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int UW        = 1,
   parameter int IW        = 1,
   parameter int EW        = 1,
   parameter int EHW       = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   hci_core_intf.target         tcdm_main,
   hci_core_intf.target         tcdm_copy,
   hci_core_intf.initiator      tcdm_out,
   input  logic                 clear_i,
   output logic                 fault_detected_o,
   output logic                 fault_sticky_o,
   output logic [CNT_WIDTH-1:0] fault_count_o
);

   localparam int BW    = DW / 8;
   localparam int REQ_W = 1 + EHW + EHW + EW + AW + 1 + DW + BW + 1 + UW + IW;
   localparam int RSP_W = 1 + DW + 1 + UW + IW + 1 + EHW + EHW + EW;
   localparam int CW    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   localparam logic [CW-1:0] LAST_WARM = CW'((DELAY > 0) ? DELAY - 1 : 0);

   typedef enum logic {WARMUP, ACTIVE} state_e;
   localparam state_e RST_STATE = (DELAY == 0) ? ACTIVE : WARMUP;

   logic [REQ_W-1:0] req_main, req_copy, req_dly;
   logic [RSP_W-1:0] rsp_out, rsp_dly;
   state_e           state_q, state_d;
   logic [CW-1:0]    warm_q, warm_d;
   logic             active, mismatch, fault_next;

   assign req_main = {tcdm_main.req, tcdm_main.ereq, tcdm_main.r_eready, tcdm_main.ecc,
                      tcdm_main.add, tcdm_main.wen, tcdm_main.data, tcdm_main.be,
                      tcdm_main.r_ready, tcdm_main.user, tcdm_main.id};
   assign req_copy = {tcdm_copy.req, tcdm_copy.ereq, tcdm_copy.r_eready, tcdm_copy.ecc,
                      tcdm_copy.add, tcdm_copy.wen, tcdm_copy.data, tcdm_copy.be,
                      tcdm_copy.r_ready, tcdm_copy.user, tcdm_copy.id};
   assign rsp_out  = {tcdm_out.gnt, tcdm_out.r_data, tcdm_out.r_valid, tcdm_out.r_user,
                      tcdm_out.r_id, tcdm_out.r_opc, tcdm_out.egnt, tcdm_out.r_evalid,
                      tcdm_out.r_ecc};

   assign {tcdm_out.req, tcdm_out.ereq, tcdm_out.r_eready, tcdm_out.ecc,
           tcdm_out.add, tcdm_out.wen, tcdm_out.data, tcdm_out.be,
           tcdm_out.r_ready, tcdm_out.user, tcdm_out.id} = req_main;
   assign {tcdm_main.gnt, tcdm_main.r_data, tcdm_main.r_valid, tcdm_main.r_user,
           tcdm_main.r_id, tcdm_main.r_opc, tcdm_main.egnt, tcdm_main.r_evalid,
           tcdm_main.r_ecc} = rsp_out;
   assign {tcdm_copy.gnt, tcdm_copy.r_data, tcdm_copy.r_valid, tcdm_copy.r_user,
           tcdm_copy.r_id, tcdm_copy.r_opc, tcdm_copy.egnt, tcdm_copy.r_evalid,
           tcdm_copy.r_ecc} = rsp_dly;

   // Delay lines: free-running shift registers, zero-depth when DELAY is 0
   if (DELAY == 0) begin : g_nodly
      assign req_dly = req_main;
      assign rsp_dly = rsp_out;
   end else begin : g_dly
      logic [REQ_W-1:0] req_sr [DELAY];
      logic [RSP_W-1:0] rsp_sr [DELAY];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < DELAY; i++) begin
               req_sr[i] <= '0;
               rsp_sr[i] <= '0;
            end
         end else begin
            req_sr[0] <= req_main;
            rsp_sr[0] <= rsp_out;
            for (int i = 1; i < DELAY; i++) begin
               req_sr[i] <= req_sr[i-1];
               rsp_sr[i] <= rsp_sr[i-1];
            end
         end
      end

      assign req_dly = req_sr[DELAY-1];
      assign rsp_dly = rsp_sr[DELAY-1];
   end

   // Warm-up FSM: compare stays masked until the delay lines hold real traffic
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RST_STATE;
         warm_q  <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      if (state_q == WARMUP) begin
         warm_d = warm_q + 1'b1;
         if (warm_q == LAST_WARM) state_d = ACTIVE;
      end
   end

   always_comb begin
      active = (state_q == ACTIVE);
   end

   assign mismatch   = (req_dly != req_copy);
   assign fault_next = mismatch & active;

   // Fault reporting: a fault in the same cycle as clear_i survives the clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fault_detected_o <= 1'b0;
         fault_sticky_o   <= 1'b0;
         fault_count_o    <= '0;
      end else begin
         fault_detected_o <= fault_next;
         fault_sticky_o   <= fault_next | (fault_sticky_o & ~clear_i);
         if (clear_i) begin
            fault_count_o <= fault_next ? CNT_WIDTH'(1) : '0;
         end else if (fault_next && (fault_count_o != '1)) begin
            fault_count_o <= fault_count_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hci_copy_sink_lockstep.sv
// Randomized scoreboard bench for two lockstep sinks (DELAY=0/CNT_WIDTH=8 and DELAY=3/CNT_WIDTH=2).
module tb_hci_copy_sink_lockstep;

   localparam int DA = 0;
   localparam int DB = 3;
   localparam int CWA = 8;
   localparam int CWB = 2;

   typedef struct packed {
      logic req; logic ereq; logic r_eready; logic ecc; logic [31:0] add; logic wen;
      logic [31:0] data; logic [3:0] be; logic r_ready; logic user; logic id;
   } req_t;

   typedef struct packed {
      logic gnt; logic [31:0] r_data; logic r_valid; logic r_user; logic r_id;
      logic r_opc; logic egnt; logic r_evalid; logic r_ecc;
   } rsp_t;

   typedef struct {
      req_t oreq; rsp_t mrsp; rsp_t crsp; logic det; logic st; logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_a = 1'b0, clr_b = 1'b0;
   logic det_a, st_a, det_b, st_b;
   logic [CWA-1:0] cnt_a;
   logic [CWB-1:0] cnt_b;
   req_t main_r = '0, copy_a = '0, copy_b = '0;
   rsp_t out_r = '0;
   req_t oreq_a, oreq_b;
   rsp_t mrsp_a, mrsp_b, crsp_a, crsp_b;

   int total = 0;
   int bad = 0;
   int ncyc = 0;
   exp_t qa[$], qb[$];
   req_t hm[$];
   rsp_t hr[$];
   logic m_det[2];
   logic m_st[2];
   int   m_cnt[2];

   always #5 clk = ~clk;

   hci_core_intf ma(), ca(), oa(), mb(), cb(), ob();

   hci_copy_sink_lockstep #(.DELAY(DA), .CNT_WIDTH(CWA)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .tcdm_main(ma), .tcdm_copy(ca), .tcdm_out(oa),
      .clear_i(clr_a), .fault_detected_o(det_a), .fault_sticky_o(st_a), .fault_count_o(cnt_a));

   hci_copy_sink_lockstep #(.DELAY(DB), .CNT_WIDTH(CWB)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .tcdm_main(mb), .tcdm_copy(cb), .tcdm_out(ob),
      .clear_i(clr_b), .fault_detected_o(det_b), .fault_sticky_o(st_b), .fault_count_o(cnt_b));

   assign {ma.req, ma.ereq, ma.r_eready, ma.ecc, ma.add, ma.wen, ma.data, ma.be, ma.r_ready, ma.user, ma.id} = main_r;
   assign {mb.req, mb.ereq, mb.r_eready, mb.ecc, mb.add, mb.wen, mb.data, mb.be, mb.r_ready, mb.user, mb.id} = main_r;
   assign {ca.req, ca.ereq, ca.r_eready, ca.ecc, ca.add, ca.wen, ca.data, ca.be, ca.r_ready, ca.user, ca.id} = copy_a;
   assign {cb.req, cb.ereq, cb.r_eready, cb.ecc, cb.add, cb.wen, cb.data, cb.be, cb.r_ready, cb.user, cb.id} = copy_b;
   assign {oa.gnt, oa.r_data, oa.r_valid, oa.r_user, oa.r_id, oa.r_opc, oa.egnt, oa.r_evalid, oa.r_ecc} = out_r;
   assign {ob.gnt, ob.r_data, ob.r_valid, ob.r_user, ob.r_id, ob.r_opc, ob.egnt, ob.r_evalid, ob.r_ecc} = out_r;

   assign oreq_a = {oa.req, oa.ereq, oa.r_eready, oa.ecc, oa.add, oa.wen, oa.data, oa.be, oa.r_ready, oa.user, oa.id};
   assign oreq_b = {ob.req, ob.ereq, ob.r_eready, ob.ecc, ob.add, ob.wen, ob.data, ob.be, ob.r_ready, ob.user, ob.id};
   assign mrsp_a = {ma.gnt, ma.r_data, ma.r_valid, ma.r_user, ma.r_id, ma.r_opc, ma.egnt, ma.r_evalid, ma.r_ecc};
   assign mrsp_b = {mb.gnt, mb.r_data, mb.r_valid, mb.r_user, mb.r_id, mb.r_opc, mb.egnt, mb.r_evalid, mb.r_ecc};
   assign crsp_a = {ca.gnt, ca.r_data, ca.r_valid, ca.r_user, ca.r_id, ca.r_opc, ca.egnt, ca.r_evalid, ca.r_ecc};
   assign crsp_b = {cb.gnt, cb.r_data, cb.r_valid, cb.r_user, cb.r_id, cb.r_opc, cb.egnt, cb.r_evalid, cb.r_ecc};

   function automatic req_t rand_req();
      req_t r;
      r.req = 1'($urandom); r.ereq = 1'($urandom); r.r_eready = 1'($urandom);
      r.ecc = 1'($urandom); r.add = $urandom; r.wen = 1'($urandom); r.data = $urandom;
      r.be = 4'($urandom); r.r_ready = 1'($urandom); r.user = 1'($urandom); r.id = 1'($urandom);
      return r;
   endfunction

   function automatic rsp_t rand_rsp();
      rsp_t r;
      r.gnt = 1'($urandom); r.r_data = $urandom; r.r_valid = 1'($urandom);
      r.r_user = 1'($urandom); r.r_id = 1'($urandom); r.r_opc = 1'($urandom);
      r.egnt = 1'($urandom); r.r_evalid = 1'($urandom); r.r_ecc = 1'($urandom);
      return r;
   endfunction

   // Corrupts one field of a copy request; data bit 5 is the most likely victim.
   function automatic req_t flip(input req_t r);
      req_t f = r;
      case ($urandom_range(0, 13))
         0: f.req = ~f.req;
         1: f.ereq = ~f.ereq;
         2: f.r_eready = ~f.r_eready;
         3: f.ecc = ~f.ecc;
         4: f.add[0] = ~f.add[0];
         5: f.wen = ~f.wen;
         7: f.be[0] = ~f.be[0];
         8: f.r_ready = ~f.r_ready;
         9: f.user = ~f.user;
         10: f.id = ~f.id;
         default: f.data[5] = ~f.data[5];
      endcase
      return f;
   endfunction

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d actual=%h required=%h", nm, ncyc, act, exp);
      end
   endtask

   // mode: 0 random, 1 tamper always, 2 tamper+clear, 3 clear only, 4 clean
   // dir: 0 random main, 1 write 0xDEADBEEF to 0x100, 2 read 0x100
   task automatic step(input bit rst_now, input int mode, input int dir);
      req_t cv[2];
      logic cl[2];
      exp_t e;
      int s, d, maxc;
      req_t dm;
      rsp_t dr;
      bit tamper, fnext;
      @(posedge clk);
      #1;
      main_r = rand_req();
      out_r = rand_rsp();
      if (dir == 1) begin
         main_r.req = 1'b1; main_r.wen = 1'b0; main_r.add = 32'h100;
         main_r.data = 32'hDEADBEEF; main_r.be = 4'hF;
      end else if (dir == 2) begin
         main_r.req = 1'b1; main_r.wen = 1'b1; main_r.add = 32'h100;
      end
      rst_n = !rst_now;
      if (rst_now) begin
         hm.delete();
         hr.delete();
      end else begin
         hm.push_back(main_r);
         hr.push_back(out_r);
      end
      s = hm.size() - 1;
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? DA : DB;
         maxc = (k == 0) ? (1 << CWA) - 1 : (1 << CWB) - 1;
         e.oreq = main_r;
         e.mrsp = out_r;
         if (rst_now) begin
            m_det[k] = 1'b0; m_st[k] = 1'b0; m_cnt[k] = 0;
            e.crsp = (d == 0) ? out_r : '0;
            e.det = 1'b0; e.st = 1'b0; e.cnt = 8'd0;
            cv[k] = rand_req();
            cl[k] = 1'b0;
         end else begin
            dm = (s >= d) ? hm[s-d] : '0;
            dr = (s >= d) ? hr[s-d] : '0;
            tamper = (mode == 1) || (mode == 2) || (mode == 0 && $urandom_range(0, 5) == 0);
            cl[k] = (mode == 2) || (mode == 3) || (mode == 0 && $urandom_range(0, 15) == 0);
            if (s < d) cv[k] = ($urandom_range(0, 1) == 1) ? rand_req() : dm;
            else cv[k] = tamper ? flip(dm) : dm;
            e.crsp = dr;
            e.det = m_det[k]; e.st = m_st[k]; e.cnt = 8'(m_cnt[k]);
            fnext = (s >= d) && (cv[k] != dm);
            m_det[k] = fnext;
            m_st[k] = fnext | (m_st[k] & !cl[k]);
            if (cl[k]) m_cnt[k] = fnext ? 1 : 0;
            else if (fnext && m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
         end
         if (k == 0) qa.push_back(e);
         else qb.push_back(e);
      end
      copy_a = cv[0]; copy_b = cv[1];
      clr_a = cl[0]; clr_b = cl[1];
   endtask

   always @(negedge clk) begin
      exp_t ea, eb;
      ncyc++;
      if (qa.size() > 0 && qb.size() > 0) begin
         ea = qa.pop_front();
         eb = qb.pop_front();
         chk("a_out_req", 80'(oreq_a), 80'(ea.oreq));
         chk("a_main_rsp", 80'(mrsp_a), 80'(ea.mrsp));
         chk("a_copy_rsp", 80'(crsp_a), 80'(ea.crsp));
         chk("a_detected", 80'(det_a), 80'(ea.det));
         chk("a_sticky", 80'(st_a), 80'(ea.st));
         chk("a_count", 80'(cnt_a), 80'(ea.cnt));
         chk("b_out_req", 80'(oreq_b), 80'(eb.oreq));
         chk("b_main_rsp", 80'(mrsp_b), 80'(eb.mrsp));
         chk("b_copy_rsp", 80'(crsp_b), 80'(eb.crsp));
         chk("b_detected", 80'(det_b), 80'(eb.det));
         chk("b_sticky", 80'(st_b), 80'(eb.st));
         chk("b_count", 80'(cnt_b), 80'(eb.cnt));
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_det[k] = 1'b0; m_st[k] = 1'b0; m_cnt[k] = 0;
      end
      repeat (2) step(1'b1, 4, 0);
      step(1'b0, 4, 1);
      step(1'b0, 4, 2);
      repeat (6) step(1'b0, 4, 0);
      repeat (60) step(1'b0, 0, 0);
      repeat (8) step(1'b0, 1, 0);
      step(1'b0, 2, 0);
      step(1'b0, 3, 0);
      repeat (5) step(1'b0, 4, 0);
      repeat (10) step(1'b0, 0, 0);
      repeat (2) step(1'b1, 4, 0);
      repeat (4) step(1'b0, 1, 0);
      repeat (6) step(1'b0, 4, 0);
      repeat (200) step(1'b0, 0, 0);
      repeat (6) step(1'b0, 1, 0);
      step(1'b0, 2, 0);
      step(1'b0, 3, 0);
      step(1'b1, 4, 0);
      repeat (80) step(1'b0, 0, 0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
